// File: rtl/riscv_multicycle_controller.sv
// Control unit for the multi-cycle RV32I datapath: a Moore sequencing FSM with
// ALU/branch decode, a retired-instruction counter and a sticky illegal flag.
module riscv_multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opc,
  input  logic [2:0]       f3,
  input  logic [6:0]       f7,
  input  logic             zero,
  input  logic             sign,
  input  logic             memready,
  output logic             pcupdate,
  output logic             pcsrc,
  output logic             adrsrc,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic [1:0]       resultsrc,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic [2:0]       alucontrol,
  output logic [2:0]       immsrc,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_ERROR
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instret;
  logic             w_retire;
  logic             w_rvalid;
  logic [2:0]       w_ralu;
  logic             w_ivalid;
  logic [2:0]       w_ialu;
  logic             w_bvalid;
  logic             w_taken;

  always_comb begin
    w_rvalid = 1'b1;
    w_ralu   = ALU_ADD;
    case (f3)
      3'b000: begin
        if (f7 == 7'b0100000)      w_ralu = ALU_SUB;
        else if (f7 != 7'b0000000) w_rvalid = 1'b0;
      end
      3'b111:  w_ralu = ALU_AND;
      3'b110:  w_ralu = ALU_OR;
      3'b010:  w_ralu = ALU_SLT;
      3'b100:  w_ralu = ALU_XOR;
      default: w_rvalid = 1'b0;
    endcase

    w_ivalid = 1'b1;
    w_ialu   = ALU_ADD;
    case (f3)
      3'b000:  w_ialu = ALU_ADD;
      3'b111:  w_ialu = ALU_AND;
      3'b110:  w_ialu = ALU_OR;
      3'b010:  w_ialu = ALU_SLT;
      3'b100:  w_ialu = ALU_XOR;
      default: w_ivalid = 1'b0;
    endcase

    // Signed overflow is deliberately ignored: blt/bge use the raw sign bit.
    w_bvalid = 1'b1;
    w_taken  = 1'b0;
    case (f3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = ~zero;
      3'b100:  w_taken = sign;
      3'b101:  w_taken = ~sign;
      default: w_bvalid = 1'b0;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    pcupdate   = 1'b0;
    pcsrc      = 1'b0;
    adrsrc     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    alucontrol = ALU_ADD;
    immsrc     = IMM_I;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        if (memready) begin
          irwrite  = 1'b1;
          pcupdate = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        immsrc  = (opc == OPC_JAL) ? IMM_J : IMM_B;
        case (opc)
          OPC_LOAD, OPC_STORE: w_next = S_MEMADR;
          OPC_OP:              w_next = S_EXECR;
          OPC_OPIMM, OPC_LUI:  w_next = S_EXECI;
          OPC_BRANCH:          w_next = S_BRANCH;
          OPC_JAL:             w_next = S_JAL;
          OPC_JALR:            w_next = S_JALR1;
          default:             w_next = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        immsrc  = (opc == OPC_LOAD) ? IMM_I : IMM_S;
        w_next  = (opc == OPC_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
        if (memready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        if (memready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_EXECR: begin
        alusrca = 2'b10;
        if (w_rvalid) begin
          alucontrol = w_ralu;
          w_next     = S_ALUWB;
        end else begin
          w_next = S_ERROR;
        end
      end
      S_EXECI: begin
        alusrcb = 2'b01;
        if (opc == OPC_LUI) begin
          alusrca = 2'b11;
          immsrc  = IMM_U;
          w_next  = S_ALUWB;
        end else begin
          alusrca = 2'b10;
          if (w_ivalid) begin
            alucontrol = w_ialu;
            w_next     = S_ALUWB;
          end else begin
            w_next = S_ERROR;
          end
        end
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 2'b10;
        alucontrol = ALU_SUB;
        if (w_bvalid) begin
          pcupdate = w_taken;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else begin
          w_next = S_ERROR;
        end
      end
      S_JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
        w_next   = S_ALUWB;
      end
      S_JALR1: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        w_next  = S_JALR2;
      end
      S_JALR2: begin
        regwrite = 1'b1;
        alusrca  = 2'b10;
        alusrcb  = 2'b01;
        pcsrc    = 1'b1;
        pcupdate = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_FETCH;
    endcase
    // FETCH with memready=1 would otherwise write PC/IR while reset is held.
    if (!rst) begin
      pcupdate = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_ERROR) r_illegal <= 1'b1;
      if (w_retire)          r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign illegal = r_illegal;
  assign instret = r_instret;

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Bench for riscv_multicycle_controller: each instruction is expanded into its
// expected per-cycle control vectors and checked every cycle, directed then random.
module tb_riscv_multicycle_controller;

  localparam int CNT_W = 4;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [6:0]       opc = 7'd0;
  logic [2:0]       f3 = 3'd0;
  logic [6:0]       f7 = 7'd0;
  logic             zero = 1'b0;
  logic             sign = 1'b0;
  logic             memready = 1'b0;
  logic             pcupdate, pcsrc, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0]       resultsrc, alusrca, alusrcb;
  logic [2:0]       alucontrol, immsrc;
  logic [CNT_W-1:0] instret;
  logic [17:0]      w_obs;

  riscv_multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opc(opc), .f3(f3), .f7(f7), .zero(zero), .sign(sign),
    .memready(memready), .pcupdate(pcupdate), .pcsrc(pcsrc), .adrsrc(adrsrc),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .alucontrol(alucontrol), .immsrc(immsrc), .illegal(illegal), .instret(instret)
  );

  assign w_obs = {pcupdate, pcsrc, adrsrc, memwrite, irwrite, regwrite,
                  resultsrc, alusrca, alusrcb, alucontrol, immsrc};

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] v;
    bit          fetch;
    bit          wt;
    bit          ret;
    bit          err;
  } phase_t;

  phase_t           ph_q[$];
  int               nvec = 0;
  int               nerr = 0;
  logic [CNT_W-1:0] cnt = '0;
  logic             ill = 1'b0;
  int               err_cycles = 10;
  logic [2:0]       rl[5] = '{3'b000, 3'b111, 3'b110, 3'b010, 3'b100};
  logic [2:0]       bl[4] = '{3'b000, 3'b001, 3'b100, 3'b101};
  logic [2:0]       xl[4] = '{3'b001, 3'b011, 3'b101, 3'b001};
  logic [2:0]       xb[4] = '{3'b010, 3'b011, 3'b110, 3'b111};
  logic [6:0]       xo[5] = '{7'h7F, 7'h00, 7'h0F, 7'h73, 7'h17};

  function automatic logic [17:0] V(input logic pcu, input logic pcs, input logic adr,
                                    input logic mw, input logic irw, input logic rw,
                                    input logic [1:0] rs, input logic [1:0] asa,
                                    input logic [1:0] asb, input logic [2:0] alu,
                                    input logic [2:0] imm);
    return {pcu, pcs, adr, mw, irw, rw, rs, asa, asb, alu, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [17:0] v, input bit f, input bit w, input bit r, input bit e);
    phase_t p;
    p.v = v; p.fetch = f; p.wt = w; p.ret = r; p.err = e;
    ph_q.push_back(p);
  endtask

  // Expected cycle-by-cycle control vectors for one instruction (memready=1 view).
  task automatic build(input logic [6:0] o, input logic [2:0] a3, input logic [6:0] a7,
                       input logic z, input logic s);
    bit         ok;
    bit         tk;
    logic [2:0] alu;
    ph_q.delete();
    push(V(0,0,0,0,0,0,2'b10,2'b00,2'b10,3'd0,3'd0), 1, 1, 0, 0);
    push(V(0,0,0,0,0,0,2'b00,2'b01,2'b01,3'd0,(o == JAL) ? 3'd3 : 3'd2), 0, 0, 0, 0);
    ok = 1; alu = 3'd0; tk = 0;
    case (o)
      LOAD: begin
        push(V(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'd0,3'd0), 0, 0, 0, 0);
        push(V(0,0,1,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0), 0, 1, 0, 0);
        push(V(0,0,0,0,0,1,2'b01,2'b00,2'b00,3'd0,3'd0), 0, 0, 1, 0);
      end
      STORE: begin
        push(V(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'd0,3'd1), 0, 0, 0, 0);
        push(V(0,0,1,1,0,0,2'b00,2'b00,2'b00,3'd0,3'd0), 0, 1, 1, 0);
      end
      OP, OPIMM: begin
        case (a3)
          3'b000: begin
            if (o == OP && a7 == 7'h20) alu = 3'd1;
            else if (o == OP && a7 != 7'h00) ok = 0;
          end
          3'b111:  alu = 3'd2;
          3'b110:  alu = 3'd3;
          3'b010:  alu = 3'd4;
          3'b100:  alu = 3'd5;
          default: ok = 0;
        endcase
        if (!ok) alu = 3'd0;
        push(V(0,0,0,0,0,0,2'b00,2'b10,(o == OP) ? 2'b00 : 2'b01,alu,3'd0), 0, 0, 0, 0);
        if (ok) push(V(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'd0,3'd0), 0, 0, 1, 0);
        else    push(18'd0, 0, 0, 0, 1);
      end
      LUI: begin
        push(V(0,0,0,0,0,0,2'b00,2'b11,2'b01,3'd0,3'd4), 0, 0, 0, 0);
        push(V(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'd0,3'd0), 0, 0, 1, 0);
      end
      BR: begin
        case (a3)
          3'b000:  tk = z;
          3'b001:  tk = !z;
          3'b100:  tk = s;
          3'b101:  tk = !s;
          default: ok = 0;
        endcase
        push(V(ok & tk,0,0,0,0,0,2'b00,2'b10,2'b00,3'd1,3'd0), 0, 0, ok, 0);
        if (!ok) push(18'd0, 0, 0, 0, 1);
      end
      JAL: begin
        push(V(1,0,0,0,0,0,2'b00,2'b01,2'b10,3'd0,3'd0), 0, 0, 0, 0);
        push(V(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'd0,3'd0), 0, 0, 1, 0);
      end
      JALR: begin
        push(V(0,0,0,0,0,0,2'b00,2'b01,2'b10,3'd0,3'd0), 0, 0, 0, 0);
        push(V(1,1,0,0,0,1,2'b00,2'b10,2'b01,3'd0,3'd0), 0, 0, 1, 0);
      end
      default: push(18'd0, 0, 0, 0, 1);
    endcase
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    rst = 1'b0;
    memready = 1'b1;
    #1;
    cnt = '0;
    ill = 1'b0;
    if (check) begin
      chk("rst_ctl", 32'(w_obs), 32'(V(0,0,0,0,0,0,2'b10,2'b00,2'b10,3'd0,3'd0)));
      chk("rst_instret", 32'(instret), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] a3, input logic [6:0] a7,
                           input logic z, input logic s, input int stall, input bit rnd,
                           input int abort_at);
    phase_t      p;
    int          k;
    bit          done;
    logic [17:0] exp;
    build(o, a3, a7, z, s);
    for (int i = 0; i < ph_q.size(); i++) begin
      p = ph_q[i];
      if (i == abort_at) begin
        do_reset(1);
        return;
      end
      if (p.err) begin
        ill = 1'b1;
        repeat (err_cycles) begin
          @(negedge clk);
          memready = 1'($urandom_range(0, 1));
          #1;
          chk("err_ctl", 32'(w_obs), 32'd0);
          chk("err_instret", 32'(instret), 32'(cnt));
          chk("err_illegal", 32'(illegal), 32'(ill));
        end
        do_reset(0);
        return;
      end
      k = 0;
      done = 0;
      while (!done) begin
        @(negedge clk);
        if (i == 0 && k == 0) begin
          opc = o; f3 = a3; f7 = a7; zero = z; sign = s;
        end
        if (p.wt)
          memready = rnd ? ((k >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0))
                         : ((p.fetch || k >= stall) ? 1'b1 : 1'b0);
        else
          memready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        exp = p.v | ((p.fetch && memready) ? V(1,0,0,0,1,0,2'b00,2'b00,2'b00,3'd0,3'd0) : 18'd0);
        chk($sformatf("ctl[opc=%b ph=%0d]", o, i), 32'(w_obs), 32'(exp));
        chk("instret", 32'(instret), 32'(cnt));
        chk("illegal", 32'(illegal), 32'(ill));
        k++;
        done = !p.wt || memready;
      end
      if (p.ret) cnt = cnt + 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] o;
    logic [2:0] a3;
    logic [6:0] a7;
    int         kind;

    do_reset(1);
    // Directed instruction mix, with memory stalls on lw/sw.
    run_instr(OP,    3'b000, 7'h00, 0, 0, 0, 0, -1);
    run_instr(LOAD,  3'b010, 7'h00, 0, 0, 2, 0, -1);
    run_instr(STORE, 3'b010, 7'h00, 0, 0, 1, 0, -1);
    run_instr(BR,    3'b000, 7'h00, 1, 0, 0, 0, -1);
    run_instr(BR,    3'b000, 7'h00, 0, 0, 0, 0, -1);
    run_instr(BR,    3'b101, 7'h00, 0, 0, 0, 0, -1);
    run_instr(BR,    3'b100, 7'h00, 0, 1, 0, 0, -1);
    run_instr(BR,    3'b001, 7'h00, 0, 0, 0, 0, -1);
    run_instr(JALR,  3'b000, 7'h00, 0, 0, 0, 0, -1);
    run_instr(JAL,   3'b000, 7'h00, 0, 0, 0, 0, -1);
    run_instr(LUI,   3'b000, 7'h00, 0, 0, 0, 0, -1);
    run_instr(OPIMM, 3'b000, 7'h00, 0, 0, 0, 0, -1);
    run_instr(OP,    3'b000, 7'h20, 0, 0, 0, 0, -1);
    // Reset while the add sits in EXECR.
    run_instr(OP,    3'b000, 7'h00, 0, 0, 0, 0, 2);

    repeat (15) run_instr(OP, 3'b000, 7'h00, 0, 0, 0, 0, -1);
    @(posedge clk); #1;
    chk("instret_allones", 32'(instret), 32'hF);
    run_instr(OP, 3'b000, 7'h00, 0, 0, 0, 0, -1);
    @(posedge clk); #1;
    chk("instret_wrap", 32'(instret), 32'h0);

    err_cycles = 10;
    run_instr(7'h7F, 3'b000, 7'h00, 0, 0, 0, 0, -1);

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 11);
      o = OP; a3 = 3'b000; a7 = 7'h00;
      case (kind)
        0:  begin o = LOAD;  a3 = 3'b010; end
        1:  begin o = STORE; a3 = 3'b010; end
        2, 3: begin
          a3 = rl[$urandom_range(0, 4)];
          a7 = (a3 == 3'b000 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        4:  begin o = OPIMM; a3 = rl[$urandom_range(0, 4)]; a7 = 7'($urandom); end
        5:  o = LUI;
        6:  o = JAL;
        7:  o = JALR;
        8, 9: begin o = BR; a3 = bl[$urandom_range(0, 3)]; end
        10: begin
          err_cycles = $urandom_range(2, 5);
          case ($urandom_range(0, 3))
            0: o = xo[$urandom_range(0, 4)];
            1: begin
              a3 = ($urandom_range(0, 1) == 1) ? xl[$urandom_range(0, 3)] : 3'b000;
              a7 = 7'h01;
            end
            2: begin o = OPIMM; a3 = xl[$urandom_range(0, 3)]; end
            default: begin o = BR; a3 = xb[$urandom_range(0, 3)]; end
          endcase
        end
        default: a7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      endcase
      run_instr(o, a3, a7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_controller.md
Name: riscv_multicycle_controller

Overview:
Main-decoder and sequencing FSM for the multi-cycle RV32I datapath, which shares one memory, one ALU and registered IR/ALUOut/data stages.
- Decodes opcode, funct3 and funct7 from the IR, and zero/sign from the ALU.
- Steps each instruction through fetch, decode, execute, memory and writeback cycles, driving every datapath enable and mux select.
- Waits on a memory-ready handshake.
- Keeps a retired-instruction counter and a sticky illegal-instruction flag.

Parameters:
CNT_W, 32, width of retired-instruction counter instret

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
opc  in  7  IR[6:0]
f3  in  3  IR[14:12]
f7  in  7  IR[31:25]
zero  in  1  ALU result == 0
sign  in  1  ALU result[31]
memready  in  1  memory has completed the current access this cycle
pcupdate  out  1  PC write enable
pcsrc  out  1  PC input: 0 = Result bus, 1 = combinational ALU result
adrsrc  out  1  memory address: 0 = PC, 1 = ALUOut
memwrite  out  1  memory write strobe
irwrite  out  1  IR and OldPC load enable
regwrite  out  1  register file write enable
resultsrc  out  2  00 ALUOut, 01 memory data register, 10 combinational ALU result
alusrca  out  2  00 PC, 01 OldPC, 10 register A, 11 zero
alusrcb  out  2  00 register B, 01 ImmExt, 10 constant 4
alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor
immsrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
illegal  out  1  sticky unsupported-instruction flag
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst=0, async):
  - state = FETCH, illegal = 0, instret = 0.
  - All enables (pcupdate, memwrite, irwrite, regwrite) are 0 while rst=0.
  - Reset mid-instruction aborts the instruction without any write.
- Outputs are Moore, decoded from state. The only exceptions are the BRANCH pcupdate term and the ALU decode, which also use opc/f3/f7/zero/sign.
- Outputs not listed for a state are 0.

States (with memready=1):
- FETCH: adrsrc=0, alusrca=00, alusrcb=10, add, resultsrc=10, pcsrc=0.
  - irwrite and pcupdate are asserted only when memready=1; the FSM then goes to DECODE.
  - Otherwise it holds FETCH with no writes.
- DECODE: alusrca=01, alusrcb=01, add, immsrc=J if opc=1101111, else B. This loads the target into ALUOut.
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 or 0110111 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR1
  - any other opcode -> ERROR
- MEMADR: alusrca=10, alusrcb=01, add; immsrc=I for loads, S for stores. Goes to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: adrsrc=1. Holds until memready=1, then goes to MEMWB.
- MEMWB: resultsrc=01, regwrite. Retires, then FETCH.
- MEMWRITE: adrsrc=1, memwrite=1 every cycle in the state. Holds until memready=1, then retires and goes to FETCH.
- EXECR: alusrca=10, alusrcb=00. Then ALUWB.
- EXECI: alusrcb=01.
  - opc 0110111 (LUI): alusrca=11, immsrc=U, add.
  - otherwise: alusrca=10, immsrc=I.
  - Then ALUWB.
- ALUWB: resultsrc=00, regwrite. Retires, then FETCH.
- BRANCH: alusrca=10, alusrcb=00, sub, resultsrc=00, pcsrc=0.
  - pcupdate = taken, where f3=000 -> zero; 001 -> ~zero; 100 -> sign; 101 -> ~sign.
  - Signed overflow is ignored.
  - Retires, then FETCH.
- JAL: alusrca=01, alusrcb=10, add, resultsrc=00, pcsrc=0, pcupdate. Then ALUWB, which writes OldPC+4.
- JALR1: alusrca=01, alusrcb=10, add, loading ALUOut = OldPC+4. Then JALR2.
- JALR2: resultsrc=00, regwrite; alusrca=10, alusrcb=01, immsrc=I, add, pcsrc=1, pcupdate. Retires, then FETCH.
- ERROR: sets illegal=1 and stays in ERROR with all enables 0 until reset.

ALU decode:
- EXECR: f3/f7 of 000/0000000 add, 000/0100000 sub, 111 and, 110 or, 010 slt, 100 xor.
- EXECI (non-LUI): f3 of 000 add, 111 and, 110 or, 010 slt, 100 xor.
- Any other combination goes to ERROR instead of ALUWB, with no regwrite.
- Branch f3 values 010, 011, 110 and 111 also go to ERROR, with no pcupdate.

Counter and latency:
- instret increments by 1 on each retire and wraps from 2^CNT_W-1 to 0.
- Latency with memready=1: lw 5 cycles; sw, R-type, I-type, lui, jal and jalr 4 cycles; branch 3 cycles. Each cycle with memready=0 adds one cycle.

Test Plan:
1. rst=0 asserted mid-EXECR -> outputs immediately FETCH-decoded, enables 0, instret=0, illegal=0; release -> FETCH next edge.
2. add (opc 0110011, f3 000, f7 0000000), memready=1 -> states FETCH, DECODE, EXECR, ALUWB; alucontrol=000 in EXECR; regwrite only in cycle 4; instret 0->1.
3. lw with memready low for 2 cycles in MEMREAD -> MEMREAD held 3 cycles, adrsrc=1 throughout; MEMWB resultsrc=01 with regwrite; total 7 cycles.
4. beq (f3 000) with zero=1 -> pcupdate=1 in BRANCH; repeat with zero=0 -> pcupdate=0; bge (f3 101) with sign=0 -> pcupdate=1; each retires in 3 cycles.
5. jalr -> JALR2 asserts regwrite=1, resultsrc=00, pcsrc=1, pcupdate=1 in the same cycle; instret increments once.
6. opc 1111111 -> ERROR with illegal=1 held for 10 cycles, no enables; instret preset to all-ones then one add retires -> instret wraps to 0.
